lockin_demod_integrator: RTL
============================

LOCKIN_DEMOD_INTEGRATOR -- requirements
Module: lockin_demod_integrator

Interface
REQ-001 Parameter SAMPLE_BITS, default 24: signed input sample width.
REQ-002 Parameter LUT_BITS, default 18: signed reference width; equals the sine LUT output width.
REQ-003 Parameter DECIM_LOG2, default 10: log2 of samples per integration block, N = 2^DECIM_LOG2; legal range 1..16.
REQ-004 Port clk  in  1: single clock; all logic rising-edge.
REQ-005 Port rst  in  1: synchronous, active-high reset.
REQ-006 Port sample_in  in  SAMPLE_BITS: signed signal sample; the upstream phase accumulator advances the LUT address on the same cycle.
REQ-007 Port sample_valid  in  1: sample_in valid this cycle; the LUT address for this sample is presented this cycle.
REQ-008 Port ref_sin  in  LUT_BITS: signed Q reference from the sine LUT; arrives one cycle after sample_valid.
REQ-009 Port ref_cos  in  LUT_BITS: signed I reference from the sine LUT; arrives one cycle after sample_valid.
REQ-010 Port clear  in  1: synchronous restart; discards the partial block.
REQ-011 Port i_out  out  SAMPLE_BITS+LUT_BITS: signed averaged in-phase result.
REQ-012 Port q_out  out  SAMPLE_BITS+LUT_BITS: signed averaged quadrature result.
REQ-013 Port out_valid  out  1: result register holds an unconsumed result.
REQ-014 Port out_ready  in  1: consumer accepts the result when out_valid and out_ready are both high.
REQ-015 Port overrun  out  1: sticky flag; a result was overwritten before being consumed.

Function
REQ-016 Stage A: on a sample_valid edge, register sample_in and the valid flag; the 1-cycle LUT read latency is matched here.
REQ-017 Stage B: on a stage-A valid edge, register full-precision signed products: prod_i = sample_d*ref_cos, prod_q = sample_d*ref_sin, each SAMPLE_BITS+LUT_BITS wide.
REQ-018 Stage C: on a stage-B valid edge, add the products to signed accumulators of width SAMPLE_BITS+LUT_BITS+DECIM_LOG2 and increment a DECIM_LOG2-bit sample counter; no saturation is required, and the width guarantees no overflow.
REQ-019 On the stage-C edge where the counter equals N-1, load i_out/q_out with (acc+prod)>>>DECIM_LOG2 (arithmetic shift, floor rounding), zero the accumulators and counter, and set out_valid.
REQ-020 Latency: the final sample's sample_valid at cycle t gives out_valid high at cycle t+3.
REQ-021 sample_valid may assert every cycle; no bubbles are inserted, and accumulation continues into the next block while the result waits.
REQ-022 Output buffer states are EMPTY and FULL. EMPTY->FULL on a new result. FULL->EMPTY on out_valid&&out_ready with no new result. FULL stays FULL on a new result.
REQ-023 New result with out_valid high and out_ready low: overwrite i_out/q_out, keep out_valid high, set overrun.
REQ-024 New result on the same cycle as an accept: the old result counts as consumed; load the new result, keep out_valid high, do not set overrun.
REQ-025 i_out/q_out hold their value while out_valid is low or out_ready is low.
REQ-026 clear zeroes the accumulators, counter and stage A/B valid flags; in-flight samples are dropped. clear does not touch i_out, q_out, out_valid or overrun.
REQ-027 A result that would complete on the clear cycle is dropped.
REQ-028 overrun clears only on rst.

Reset
REQ-029 rst zeroes the accumulators, counter, pipeline valid flags, i_out, q_out, out_valid and overrun; rst has priority over clear and sample_valid.
REQ-030 rst mid-block discards partial data; the first post-reset block counts from the first sample_valid after rst deasserts.

Structure
REQ-031 Widths SAMPLE_BITS, LUT_BITS, PROD_BITS = SAMPLE_BITS+LUT_BITS, and DECIM_LOG2 defaults belong in the shared lock-in package, alongside the LUT parameters.
REQ-032 One sub-module is natural: lockin_mac_lane (stage B multiply plus stage C accumulate), instantiated twice for I and Q; counter and output buffer live in the top level.

Verification (DECIM_LOG2=2, N=4, SAMPLE_BITS=24, LUT_BITS=18)
REQ-033 4 consecutive sample_valid, sample=1000, ref_cos=131071, ref_sin=0, out_ready=1 -> out_valid at cycle t+3 after the 4th; i_out=131071000, q_out=0.
REQ-034 Samples 1,2,3,4 with ref_cos=4, ref_sin=-4 -> i_out=10, q_out=-10; sample=-1 x4 with ref_cos=1 -> i_out=-1.
REQ-035 8 samples with out_ready=0: first block gives i_out=A; second block of different value gives i_out=B; overrun=1 and out_valid stays 1; then out_ready=1 for one cycle -> out_valid=0, overrun stays 1.
REQ-036 Accept coincident with the next result completing, valid every cycle -> out_valid stays 1, new value loaded, overrun=0.
REQ-037 clear after 2 of 4 samples, then 4 samples of 5 with ref_cos=2 -> a single result i_out=10 with no contamination; repeat using rst mid-block -> same result, and all outputs read 0 immediately after rst.

Source files
------------

// File: rtl/lockin_demod_integrator_pkg.sv
// ---------------------------------------------------------------------------
// lockin_demod_integrator_pkg
// Shared lock-in definitions: default datapath widths, the sine LUT geometry
// that feeds the demodulator references, the output buffer state type and a
// small helper for the accumulator width.
// No ports (package).
// ---------------------------------------------------------------------------
package lockin_demod_integrator_pkg;

  // Default datapath widths
  localparam int SAMPLE_BITS_DEF = 24;
  localparam int LUT_BITS_DEF    = 18;
  localparam int PROD_BITS_DEF   = SAMPLE_BITS_DEF + LUT_BITS_DEF;
  localparam int DECIM_LOG2_DEF  = 10;

  // Sine LUT geometry; the LUT output width is LUT_BITS_DEF and a read takes
  // one clock, which stage A of the demodulator absorbs.
  localparam int LUT_ADDR_BITS    = 10;
  localparam int LUT_DEPTH        = 1 << LUT_ADDR_BITS;
  localparam int LUT_READ_LATENCY = 1;

  // Single-entry result buffer in front of the consumer
  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } bufState_t;

  // Summing 2^decimLog2 products of prodBits each needs decimLog2 extra bits
  // of headroom, so the accumulators can never overflow.
  function automatic int accBits(input int prodBits, input int decimLog2);
    return prodBits + decimLog2;
  endfunction

endpackage

// File: rtl/lockin_mac_lane.sv
// ---------------------------------------------------------------------------
// lockin_mac_lane
// One demodulation lane (I or Q): stage B multiplies the delayed sample by
// the LUT reference at full precision, stage C accumulates the products over
// one integration block. o_result is the block average that the top level
// captures on the block's last sample.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_clear      synchronous restart, zeroes the accumulator
//   i_validA     stage-A sample valid; enables the product register
//   i_sample     stage-A delayed signed sample
//   i_ref        signed LUT reference aligned with i_sample
//   i_validB     stage-B product valid; enables accumulation
//   i_blockDone  this product is the last of the block
//   o_result     (acc + prod) >>> DECIM_LOG2, truncated to PROD_BITS
// ---------------------------------------------------------------------------
module lockin_mac_lane
  import lockin_demod_integrator_pkg::*;
#(
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
  parameter int LUT_BITS    = LUT_BITS_DEF,
  parameter int DECIM_LOG2  = DECIM_LOG2_DEF
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_clear,
  input  logic                                 i_validA,
  input  logic signed [SAMPLE_BITS-1:0]        i_sample,
  input  logic signed [LUT_BITS-1:0]           i_ref,
  input  logic                                 i_validB,
  input  logic                                 i_blockDone,
  output logic signed [SAMPLE_BITS+LUT_BITS-1:0] o_result
);

  localparam int PROD_BITS = SAMPLE_BITS + LUT_BITS;
  localparam int ACC_BITS  = accBits(PROD_BITS, DECIM_LOG2);

  logic signed [PROD_BITS-1:0] r_prod;
  logic signed [ACC_BITS-1:0]  r_acc;
  logic signed [PROD_BITS-1:0] w_prodFull;
  logic signed [ACC_BITS-1:0]  w_prodExt;
  logic signed [ACC_BITS-1:0]  w_sum;

  // Both operands are sign-extended to the product width first so the
  // multiply is carried out at full signed precision.
  assign w_prodFull = PROD_BITS'(i_sample) * PROD_BITS'(i_ref);

  assign w_prodExt = ACC_BITS'(r_prod);
  assign w_sum     = r_acc + w_prodExt;

  // Dropping the low DECIM_LOG2 bits of a signed sum is an arithmetic shift
  // with floor rounding; the remaining bits are exactly PROD_BITS wide.
  assign o_result = w_sum[ACC_BITS-1:DECIM_LOG2];

  // Stage B: product register. It holds on clear because the valid flag
  // that follows it is dropped by the top level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prod <= '0;
    end else if (i_validA) begin
      r_prod <= w_prodFull;
    end
  end

  // Stage C: accumulate; the last product of a block restarts the
  // accumulator at zero because its contribution leaves via o_result.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_acc <= '0;
    end else if (i_validB) begin
      if (i_blockDone) begin
        r_acc <= '0;
      end else begin
        r_acc <= w_sum;
      end
    end
  end

endmodule

// File: rtl/lockin_demod_integrator.sv
// ---------------------------------------------------------------------------
// lockin_demod_integrator
// Lock-in demodulator with block integrate-and-dump. Each sample is
// multiplied by the cosine (I) and sine (Q) references and 2^DECIM_LOG2
// products are averaged into one I/Q result, held in a one-entry buffer with
// a valid/ready handshake and a sticky overrun flag.
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   sample_in     signed sample, valid with sample_valid
//   sample_valid  sample strobe; LUT address for this sample issued now
//   ref_sin       signed Q reference, one cycle after sample_valid
//   ref_cos       signed I reference, one cycle after sample_valid
//   clear         synchronous restart of the partial block
//   i_out         signed averaged in-phase result
//   q_out         signed averaged quadrature result
//   out_valid     result buffer holds an unconsumed result
//   out_ready     consumer accepts when out_valid and out_ready are high
//   overrun       sticky: a result was overwritten before being consumed
// ---------------------------------------------------------------------------
module lockin_demod_integrator
  import lockin_demod_integrator_pkg::*;
#(
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
  parameter int LUT_BITS    = LUT_BITS_DEF,
  parameter int DECIM_LOG2  = DECIM_LOG2_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic signed [SAMPLE_BITS-1:0]          sample_in,
  input  logic                                   sample_valid,
  input  logic signed [LUT_BITS-1:0]             ref_sin,
  input  logic signed [LUT_BITS-1:0]             ref_cos,
  input  logic                                   clear,
  output logic signed [SAMPLE_BITS+LUT_BITS-1:0] i_out,
  output logic signed [SAMPLE_BITS+LUT_BITS-1:0] q_out,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   overrun
);

  localparam int PROD_BITS = SAMPLE_BITS + LUT_BITS;

  logic signed [SAMPLE_BITS-1:0] r_sampleD;
  logic                          r_validA;
  logic                          r_validB;
  logic [DECIM_LOG2-1:0]         r_count;
  bufState_t                     r_bufState;
  bufState_t                     w_bufNext;
  logic                          r_overrun;
  logic                          w_overrunNext;
  logic signed [PROD_BITS-1:0]   r_iOut;
  logic signed [PROD_BITS-1:0]   r_qOut;
  logic signed [PROD_BITS-1:0]   w_iResult;
  logic signed [PROD_BITS-1:0]   w_qResult;
  logic                          w_blockDone;
  logic                          w_newResult;

  // The product entering stage C is the last of the block when the counter
  // has reached N-1. A result finishing on a clear cycle is thrown away.
  assign w_blockDone = r_validB && (r_count == '1);
  assign w_newResult = w_blockDone && !clear;

  // Stage A: delay the sample by one cycle so it meets its LUT reference.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sampleD <= '0;
    end else if (sample_valid) begin
      r_sampleD <= sample_in;
    end
  end

  // Pipeline valid flags; clear drops whatever is in flight.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_validA <= 1'b0;
      r_validB <= 1'b0;
    end else begin
      r_validA <= sample_valid;
      r_validB <= r_validA;
    end
  end

  // Samples-per-block counter, advanced by each product reaching stage C.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (r_validB) begin
      if (w_blockDone) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  lockin_mac_lane #(
    .SAMPLE_BITS (SAMPLE_BITS),
    .LUT_BITS    (LUT_BITS),
    .DECIM_LOG2  (DECIM_LOG2)
  ) u_laneI (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clear     (clear),
    .i_validA    (r_validA),
    .i_sample    (r_sampleD),
    .i_ref       (ref_cos),
    .i_validB    (r_validB),
    .i_blockDone (w_blockDone),
    .o_result    (w_iResult)
  );

  lockin_mac_lane #(
    .SAMPLE_BITS (SAMPLE_BITS),
    .LUT_BITS    (LUT_BITS),
    .DECIM_LOG2  (DECIM_LOG2)
  ) u_laneQ (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clear     (clear),
    .i_validA    (r_validA),
    .i_sample    (r_sampleD),
    .i_ref       (ref_sin),
    .i_validB    (r_validB),
    .i_blockDone (w_blockDone),
    .o_result    (w_qResult)
  );

  // Output buffer next state. A new result always leaves the buffer full;
  // it only counts as an overrun when the old result was not taken on the
  // same cycle.
  always_comb begin
    w_bufNext     = r_bufState;
    w_overrunNext = r_overrun;
    case (r_bufState)
      BUF_EMPTY: begin
        if (w_newResult) begin
          w_bufNext = BUF_FULL;
        end
      end
      BUF_FULL: begin
        if (w_newResult) begin
          w_bufNext = BUF_FULL;
          if (!out_ready) begin
            w_overrunNext = 1'b1;
          end
        end else if (out_ready) begin
          w_bufNext = BUF_EMPTY;
        end
      end
      default: begin
        w_bufNext = BUF_EMPTY;
      end
    endcase
  end

  // Output buffer registers; results are only written on a new result, so
  // they hold steady while the consumer is not accepting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bufState <= BUF_EMPTY;
      r_overrun  <= 1'b0;
      r_iOut     <= '0;
      r_qOut     <= '0;
    end else begin
      r_bufState <= w_bufNext;
      r_overrun  <= w_overrunNext;
      if (w_newResult) begin
        r_iOut <= w_iResult;
        r_qOut <= w_qResult;
      end
    end
  end

  assign i_out     = r_iOut;
  assign q_out     = r_qOut;
  assign out_valid = (r_bufState == BUF_FULL);
  assign overrun   = r_overrun;

endmodule
